seq_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider; inverse operation of the team's array multiplier.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and is driven by a start/done handshake from the controlling FSM.
- Unsigned by default; signed mode selectable at compile time.

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // acc_q starts as the dividend magnitude and fills with quotient bits from the LSB.
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH);
          zero_d = (divisor == '0);
          dbz_d  = 1'b0;
          busy_d = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
          acc_d   = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
          q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg_d = dividend[WIDTH-1];
`else
          acc_d   = dividend;
          dvs_d   = divisor;
`endif
          state_d = (divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        acc_d = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
          dbz_d       = 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          quotient_d  = q_neg_q ? -acc_q : acc_q;
          remainder_d = r_neg_q ? -rem_q : rem_q;
`else
          quotient_d  = acc_q;
          remainder_d = rem_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8), one line per transaction.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one accepting edge (E0); returns just after E0.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Edges after E0 until done is seen; -1 on timeout.
  task automatic wait_done(output int n);
    bit found = 0;
    n = -1;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick();
      if (done) begin
        n = i;
        found = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (quotient !== 8'h00) begin errors++; $display("FAIL reset_q got=%h want=00", quotient); end
    checks++; if (remainder !== 8'h00) begin errors++; $display("FAIL reset_r got=%h want=00", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    $display("reset: busy=%b done=%b q=%h r=%h dbz=%b", busy, done, quotient, remainder, div_by_zero);
  endtask

  task automatic test_basic();
    bit busy_ok = 1;
    launch(8'd100, 8'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0 got=%b want=1", busy); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
    end
    checks++; if (!busy_ok) begin errors++; $display("FAIL basic_busy_e1_e8 got=0 want=1"); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_e9 got=%b want=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_e9 got=%b want=0", busy); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_q got=%0d want=14", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL basic_r got=%0d want=2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b want=0", div_by_zero); end
    $display("100/7: q=%0d r=%0d dbz=%b", quotient, remainder, div_by_zero);
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_q_hold got=%0d want=14", quotient); end
  endtask

  task automatic test_extremes();
    int n;
    launch(8'd255, 8'd1);
    wait_done(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL ext1_latency got=%0d want=9", n); end
    checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL ext1_q got=%0d want=255", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL ext1_r got=%0d want=0", remainder); end
    $display("255/1: lat=%0d q=%0d r=%0d", n, quotient, remainder);
    tick();
    launch(8'd3, 8'd200);
    wait_done(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL ext2_latency got=%0d want=9", n); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL ext2_q got=%0d want=0", quotient); end
    checks++; if (remainder !== 8'd3) begin errors++; $display("FAIL ext2_r got=%0d want=3", remainder); end
    $display("3/200: lat=%0d q=%0d r=%0d", n, quotient, remainder);
    tick();
  endtask

  task automatic test_div_zero();
    int n;
    launch(8'd5, 8'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy_e0 got=%b want=1", busy); end
    wait_done(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency got=%0d want=1", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy_e1 got=%b want=0", busy); end
    checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dz_q got=%h want=ff", quotient); end
    checks++; if (remainder !== 8'd5) begin errors++; $display("FAIL dz_r got=%0d want=5", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
    $display("5/0: lat=%0d q=%h r=%0d dbz=%b", n, quotient, remainder, div_by_zero);
    tick();
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold got=%b want=1", div_by_zero); end
    launch(8'd10, 8'd3);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_on_start got=%b want=0", div_by_zero); end
    checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dz_q_kept got=%h want=ff", quotient); end
    wait_done(n);
    checks++; if (quotient !== 8'd3 || remainder !== 8'd1) begin
      errors++; $display("FAIL dz_followup got=%0d/%0d want=3/1", quotient, remainder);
    end
    $display("10/3: lat=%0d q=%0d r=%0d dbz=%b", n, quotient, remainder, div_by_zero);
    tick();
  endtask

  task automatic test_reset_abort();
    int n;
    bit quiet = 1;
    launch(8'd100, 8'd7);
    tick(); tick(); tick();
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl got=busy%b/done%b want=0/0", busy, done);
    end
    checks++; if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got=%h/%h/%b want=00/00/0", quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL abort_no_done got=activity want=idle"); end
    $display("abort: outputs cleared, idle=%0b", quiet);
    launch(8'd50, 8'd5);
    wait_done(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL abort_next_latency got=%0d want=9", n); end
    checks++; if (quotient !== 8'd10 || remainder !== 8'd0) begin
      errors++; $display("FAIL abort_next got=%0d/%0d want=10/0", quotient, remainder);
    end
    $display("50/5: lat=%0d q=%0d r=%0d", n, quotient, remainder);
    tick();
  endtask

  task automatic test_back_to_back();
    int first_n = -1;
    int second_n = -1;
    bit stable = 1;
    logic [7:0] exp_q, exp_r;
    logic [7:0] held_q, held_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
    exp_q = 8'hFA; exp_r = 8'hFE;
`else
    exp_q = 8'd22; exp_r = 8'd2;
`endif
    dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    for (int i = 0; i <= 40 && second_n < 0; i++) begin
      tick();
      if (done) begin
        if (first_n < 0) begin
          first_n = i;
          held_q = quotient;
          held_r = remainder;
        end else begin
          second_n = i;
          start = 1'b0;
        end
      end else if (first_n >= 0 && (quotient !== held_q || remainder !== held_r)) begin
        stable = 0;
      end
    end
    start = 1'b0;
    checks++; if (first_n !== 9) begin errors++; $display("FAIL b2b_first got=%0d want=9", first_n); end
    checks++; if (second_n - first_n !== 10) begin
      errors++; $display("FAIL b2b_spacing got=%0d want=10", second_n - first_n);
    end
    checks++; if (held_q !== exp_q || held_r !== exp_r) begin
      errors++; $display("FAIL b2b_result1 got=%h/%h want=%h/%h", held_q, held_r, exp_q, exp_r);
    end
    checks++; if (quotient !== exp_q || remainder !== exp_r) begin
      errors++; $display("FAIL b2b_result2 got=%h/%h want=%h/%h", quotient, remainder, exp_q, exp_r);
    end
    checks++; if (!stable) begin errors++; $display("FAIL b2b_hold got=changed want=stable"); end
    $display("200/9 x2: done at %0d and %0d q=%h r=%h", first_n, second_n, quotient, remainder);
    tick();
    tick();
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    int n;
    launch(8'hF9, 8'd2);
    wait_done(n);
    checks++; if (quotient !== 8'hFD || remainder !== 8'hFF) begin
      errors++; $display("FAIL sgn_m7_2 got=%h/%h want=fd/ff", quotient, remainder);
    end
    $display("-7/2: q=%h r=%h", quotient, remainder);
    tick();
    launch(8'd7, 8'hFE);
    wait_done(n);
    checks++; if (quotient !== 8'hFD || remainder !== 8'h01) begin
      errors++; $display("FAIL sgn_7_m2 got=%h/%h want=fd/01", quotient, remainder);
    end
    $display("7/-2: q=%h r=%h", quotient, remainder);
    tick();
    launch(8'h80, 8'hFF);
    wait_done(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL sgn_ovf_latency got=%0d want=9", n); end
    checks++; if (quotient !== 8'h80 || remainder !== 8'h00 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL sgn_ovf got=%h/%h/%b want=80/00/0", quotient, remainder, div_by_zero);
    end
    $display("-128/-1: q=%h r=%h dbz=%b", quotient, remainder, div_by_zero);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_reset_abort();
    test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
